// File: rtl/pipelined_hadamard_unit.sv
// Two-stage Hadamard / dot-product unit with valid/ready flow control.
// S1 holds full products, S2 holds wrapped products plus exact sum.
module pipelined_hadamard_unit #(
   parameter int WIDTH  = 32,
   parameter int SIZE   = 9,
   parameter bit SIGNED = 1'b1,
   parameter int ACC_W  = 2*WIDTH+$clog2(SIZE)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        mode,
   input  logic [SIZE-1:0][WIDTH-1:0]  kernel,
   input  logic [SIZE-1:0][WIDTH-1:0]  patch,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_mode,
   output logic [SIZE-1:0][WIDTH-1:0]  res,
   output logic [ACC_W-1:0]            dot
);

   localparam int PW = 2*WIDTH;

   logic [PW-1:0]    w_prod [SIZE];
   logic [ACC_W-1:0] w_ext  [SIZE];
   logic [ACC_W-1:0] w_sum;
   logic             w_ld1;
   logic             w_ld2;

   logic                       r_s1_valid;
   logic                       r_s2_valid;
   logic                       r_m1;
   logic [PW-1:0]              r_p1 [SIZE];
   logic [SIZE-1:0][WIDTH-1:0] r_res;
   logic [ACC_W-1:0]           r_dot;
   logic                       r_mode;

   for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
      if (SIGNED) begin : g_s
         logic signed [PW-1:0] w_a;
         logic signed [PW-1:0] w_b;
         assign w_a = PW'($signed(kernel[gi]));
         assign w_b = PW'($signed(patch[gi]));
         assign w_prod[gi] = w_a * w_b;
         assign w_ext[gi] = ACC_W'($signed(r_p1[gi]));
      end else begin : g_u
         logic [PW-1:0] w_a;
         logic [PW-1:0] w_b;
         assign w_a = PW'(kernel[gi]);
         assign w_b = PW'(patch[gi]);
         assign w_prod[gi] = w_a * w_b;
         assign w_ext[gi] = ACC_W'(r_p1[gi]);
      end
   end

   // Sum is exact: ACC_W has clog2(SIZE) guard bits over one product.
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < SIZE; i++) begin
         w_sum = w_sum + w_ext[i];
      end
   end

   assign w_ld2    = r_s1_valid && (!r_s2_valid || out_ready);
   assign in_ready = !r_s1_valid || w_ld2;
   assign w_ld1    = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_m1       <= 1'b0;
         for (int i = 0; i < SIZE; i++) begin
            r_p1[i] <= '0;
         end
      end else begin
         if (w_ld1) begin
            r_s1_valid <= 1'b1;
            r_m1       <= mode;
            for (int i = 0; i < SIZE; i++) begin
               r_p1[i] <= w_prod[i];
            end
         end else if (w_ld2) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_res      <= '0;
         r_dot      <= '0;
         r_mode     <= 1'b0;
      end else begin
         if (w_ld2) begin
            r_s2_valid <= 1'b1;
            r_dot      <= w_sum;
            r_mode     <= r_m1;
            for (int i = 0; i < SIZE; i++) begin
               r_res[i] <= r_p1[i][WIDTH-1:0];
            end
         end else if (out_ready) begin
            r_s2_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_mode  = r_mode;
   assign res       = r_res;
   assign dot       = r_dot;

endmodule
